// File: rtl/tagv_array.sv
// Tag/valid store for the set-associative data cache: per-way {valid, tag} arrays with a
// registered write-first read port, hit/victim outputs and a hardware invalidate sweeper.
//
// state    | meaning
// ST_SWEEP | clearing one set per cycle at index cnt; lookups and writes refused
// ST_READY | servicing lookups, writes (we) and set invalidates (inv_set)
module tagv_array #(
  parameter  int WAYS     = 4,
  parameter  int INDEX_W  = 6,
  parameter  int TAG_W    = 20,
  parameter  int OFFSET_W = 6,
  localparam int WAY_W    = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               r_en,
  input  logic [31:0]        r_addr,
  input  logic [TAG_W-1:0]   tag,
  input  logic [31:0]        w_addr,
  input  logic [WAYS-1:0]    we,
  input  logic               inv_set,
  input  logic               inv_all,
  input  logic [WAYS-1:0]    way_sel,
  output logic [WAYS-1:0]    hit,
  output logic               cache_hit,
  output logic [WAY_W-1:0]   hit_way,
  output logic               multi_hit,
  output logic [TAG_W-1:0]   replace_tag,
  output logic               replace_vld,
  output logic               busy
);

  localparam int SETS  = 2 ** INDEX_W;
  localparam int CNT_W = INDEX_W + 1;

  typedef enum logic {ST_SWEEP, ST_READY} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TAG_W:0]     mem_q [WAYS][SETS];
  logic [TAG_W:0]     rd_q  [WAYS];
  logic [TAG_W:0]     rd_d  [WAYS];
  logic [TAG_W:0]     wr_data [WAYS];
  logic [WAYS-1:0]    wr_en;
  logic [INDEX_W-1:0] wr_idx;
  logic [INDEX_W-1:0] r_idx;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               sweep_last;
  logic               sel_onehot;
  logic [TAG_W-1:0]   sel_tag;
  logic               sel_vld;
  logic               unused_addr_bits;

  assign r_idx      = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_idx      = w_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_tag      = w_addr[31:32-TAG_W];
  assign busy       = (state_q == ST_SWEEP);
  assign sweep_last = (cnt_q == CNT_W'(SETS - 1));
  assign unused_addr_bits = ^{r_addr[31:32-TAG_W], r_addr[OFFSET_W-1:0], w_addr[OFFSET_W-1:0]};

  // Single write port: the sweeper owns it while busy, otherwise inv_set wins over we.
  always_comb begin
    wr_idx = w_idx;
    wr_en  = '0;
    for (int w = 0; w < WAYS; w++) wr_data[w] = '0;
    if (state_q == ST_SWEEP) begin
      wr_idx = cnt_q[INDEX_W-1:0];
      wr_en  = '1;
    end else if (inv_set) begin
      wr_en = '1;
    end else begin
      wr_en = we;
      for (int w = 0; w < WAYS; w++) wr_data[w] = {1'b1, w_tag};
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (wr_en[w]) mem_q[w][wr_idx] <= wr_data[w];
    end
  end

  // Write-first read: a same-edge write to the looked-up set is forwarded per way.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_d[w] = rd_q[w];
      if (r_en && state_q == ST_READY) begin
        rd_d[w] = (wr_en[w] && wr_idx == r_idx) ? wr_data[w] : mem_q[w][r_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      for (int w = 0; w < WAYS; w++) rd_q[w] <= '0;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          if (inv_all) begin
            cnt_q <= '0;
          end else if (sweep_last) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            for (int w = 0; w < WAYS; w++) rd_q[w] <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          for (int w = 0; w < WAYS; w++) rd_q[w] <= rd_d[w];
          if (inv_all) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = rd_q[w][TAG_W] && (rd_q[w][TAG_W-1:0] == tag) && !busy;
    end
  end

  assign cache_hit = |hit;
  assign multi_hit = |(hit & (hit - WAYS'(1)));

  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i]) hit_way = WAY_W'(i);
    end
  end

  assign sel_onehot = (way_sel != '0) && ((way_sel & (way_sel - WAYS'(1))) == '0);

  always_comb begin
    sel_tag = '0;
    sel_vld = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_sel[w]) begin
        sel_tag = rd_q[w][TAG_W-1:0];
        sel_vld = rd_q[w][TAG_W];
      end
    end
  end

  assign replace_tag = sel_onehot ? sel_tag : '0;
  assign replace_vld = sel_onehot && sel_vld && !busy;

endmodule

// File: tb/tb_tagv_array.sv
// Randomised plus directed bench for tagv_array: a set-level reference model predicts each
// lookup, the expectation is queued at issue and a negedge monitor compares it.
module tb_tagv_array;

  localparam int WAYS = 4;
  localparam int INDEX_W = 6;
  localparam int TAG_W = 20;
  localparam int OFFSET_W = 6;
  localparam int SETS = 64;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              r_en = 1'b0;
  logic [31:0]       r_addr = '0;
  logic [TAG_W-1:0]  tag = '0;
  logic [31:0]       w_addr = '0;
  logic [WAYS-1:0]   we = '0;
  logic              inv_set = 1'b0;
  logic              inv_all = 1'b0;
  logic [WAYS-1:0]   way_sel = '0;
  logic [WAYS-1:0]   hit;
  logic              cache_hit;
  logic [1:0]        hit_way;
  logic              multi_hit;
  logic [TAG_W-1:0]  replace_tag;
  logic              replace_vld;
  logic              busy;

  tagv_array #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rstn(rstn), .r_en(r_en), .r_addr(r_addr), .tag(tag), .w_addr(w_addr),
    .we(we), .inv_set(inv_set), .inv_all(inv_all), .way_sel(way_sel), .hit(hit),
    .cache_hit(cache_hit), .hit_way(hit_way), .multi_hit(multi_hit),
    .replace_tag(replace_tag), .replace_vld(replace_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [WAYS-1:0]  hit;
    logic             ch;
    logic [1:0]       hw;
    logic             mh;
    logic [TAG_W-1:0] rt;
    logic             rv;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bit               mv [WAYS][SETS];
  logic [TAG_W-1:0] mt [WAYS][SETS];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: lookup results are presented in the cycle after the r_en edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].cyc < cyc) begin
        chk("stale_expectation", 64'(q[0].cyc), 64'(cyc));
        void'(q.pop_front());
      end else if (q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("hit", 64'(hit), 64'(e.hit));
        chk("cache_hit", 64'(cache_hit), 64'(e.ch));
        chk("hit_way", 64'(hit_way), 64'(e.hw));
        chk("multi_hit", 64'(multi_hit), 64'(e.mh));
        chk("replace_tag", 64'(replace_tag), 64'(e.rt));
        chk("replace_vld", 64'(replace_vld), 64'(e.rv));
      end
    end
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[OFFSET_W+INDEX_W-1:OFFSET_W]);
  endfunction

  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t, input int i);
    logic [INDEX_W-1:0]  iv;
    logic [OFFSET_W-1:0] ov;
    iv = INDEX_W'(i);
    ov = OFFSET_W'($urandom);
    return {t, iv, ov};
  endfunction

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        mv[w][s] = 1'b0;
        mt[w][s] = '0;
      end
  endtask

  // One two-cycle operation: optional write/invalidate and optional lookup on the same edge.
  task automatic op(input bit ren, input logic [31:0] ra, input logic [TAG_W-1:0] t,
                    input logic [WAYS-1:0] ws, input logic [WAYS-1:0] wev, input bit invs,
                    input logic [31:0] wa);
    int wi, ri;
    exp_t e;
    wi = idx_of(wa);
    ri = idx_of(ra);
    r_en = ren; r_addr = ra; we = wev; inv_set = invs; w_addr = wa;
    for (int w = 0; w < WAYS; w++) begin
      if (invs) begin
        mv[w][wi] = 1'b0; mt[w][wi] = '0;
      end else if (wev[w]) begin
        mv[w][wi] = 1'b1; mt[w][wi] = wa[31:32-TAG_W];
      end
    end
    if (ren) begin
      e.cyc = cyc + 1;
      e.hit = '0; e.hw = '0; e.rt = '0; e.rv = 1'b0;
      for (int w = 0; w < WAYS; w++) e.hit[w] = mv[w][ri] && (mt[w][ri] == t);
      for (int w = WAYS - 1; w >= 0; w--) if (e.hit[w]) e.hw = 2'(w);
      e.ch = (e.hit != '0);
      e.mh = ($countones(e.hit) > 1);
      if ($countones(ws) == 1)
        for (int w = 0; w < WAYS; w++) if (ws[w]) begin e.rt = mt[w][ri]; e.rv = mv[w][ri]; end
      q.push_back(e);
    end
    @(posedge clk); #1;
    r_en = 1'b0; we = '0; inv_set = 1'b0; tag = t; way_sel = ws;
    @(posedge clk); #1;
  endtask

  task automatic wait_sweep(input string name, input int exp_n);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > 400) break;
      n++;
    end
    chk(name, 64'(n), 64'(exp_n));
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TAG_W-1:0] pool [4];
    logic [31:0] a;
    int n;
    pool[0] = 20'h11111; pool[1] = 20'h22222; pool[2] = 20'hABCDE; pool[3] = 20'h12345;
    model_clear();

    #3;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_cache_hit", 64'(cache_hit), 64'd0);
    chk("rst_hit_way", 64'(hit_way), 64'd0);
    chk("rst_multi_hit", 64'(multi_hit), 64'd0);
    chk("rst_replace_tag", 64'(replace_tag), 64'd0);
    chk("rst_replace_vld", 64'(replace_vld), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    wait_sweep("reset_sweep_len", SETS);

    for (int s = 0; s < SETS; s++) begin
      a = mk_addr(20'($urandom), s);
      op(1'b1, a, 20'($urandom), 4'b0001 << $urandom_range(0, 3), '0, 1'b0, '0);
    end

    a = 32'hABCDE040;
    op(1'b0, '0, '0, '0, 4'b0100, 1'b0, a);
    op(1'b1, a, 20'hABCDE, 4'b0100, '0, 1'b0, '0);

    a = mk_addr(20'h22222, 5);
    op(1'b1, a, 20'h22222, 4'b0001, 4'b0001, 1'b0, a);
    op(1'b1, a, 20'h22222, 4'b0001, '0, 1'b1, a);

    a = mk_addr(20'h12345, 9);
    op(1'b0, '0, '0, '0, 4'b0010, 1'b0, a);
    op(1'b1, a, 20'h12345, 4'b0010, '0, 1'b0, '0);
    op(1'b1, a, 20'h12345, 4'b0011, '0, 1'b0, '0);

    for (int k = 0; k < 300; k++) begin
      int kind;
      logic [31:0] wa, ra;
      kind = $urandom_range(0, 3);
      wa = mk_addr(pool[$urandom_range(0, 3)], $urandom_range(0, 3));
      ra = mk_addr(pool[$urandom_range(0, 3)], (kind == 3) ? idx_of(wa) : $urandom_range(0, 3));
      case (kind)
        0: op(1'b0, '0, '0, '0, 4'($urandom), 1'b0, wa);
        1: op(1'b0, '0, '0, '0, '0, 1'b1, wa);
        2: op(1'b1, ra, pool[$urandom_range(0, 3)], 4'($urandom), '0, 1'b0, '0);
        default: op(1'b1, ra, pool[$urandom_range(0, 3)], 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0), wa);
      endcase
    end

    // Flush, restarted 30 cycles in; a write during the sweep must be dropped.
    inv_all = 1'b1;
    @(posedge clk); #1;
    inv_all = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > 400) break;
      n++;
      if (n == 30) inv_all = 1'b1;
      if (n == 31) inv_all = 1'b0;
      if (n == 40) begin we = 4'b0010; w_addr = mk_addr(20'h77777, 3); end
      if (n == 41) we = '0;
    end
    chk("restart_sweep_len", 64'(n), 64'(30 + SETS));
    model_clear();
    @(posedge clk); #1;
    a = mk_addr(20'h77777, 3);
    op(1'b1, a, 20'h77777, 4'b0010, '0, 1'b0, '0);
    a = 32'hABCDE040;
    op(1'b1, a, 20'hABCDE, 4'b0100, '0, 1'b0, '0);

    a = mk_addr(20'h55555, 12);
    op(1'b0, '0, '0, '0, 4'b1001, 1'b0, a);
    op(1'b1, a, 20'h55555, 4'b1000, '0, 1'b0, '0);

    // Lookup outside the scoreboard, then reset while its result is on the outputs.
    r_en = 1'b1; r_addr = a;
    @(posedge clk); #1;
    r_en = 1'b0; tag = 20'h55555; way_sel = 4'b0001;
    #1;
    chk("pre_reset_hit", 64'(hit), 64'b1001);
    rstn = 1'b0;
    #1;
    chk("midreset_hit", 64'(hit), 64'd0);
    chk("midreset_cache_hit", 64'(cache_hit), 64'd0);
    chk("midreset_hit_way", 64'(hit_way), 64'd0);
    chk("midreset_multi_hit", 64'(multi_hit), 64'd0);
    chk("midreset_replace_tag", 64'(replace_tag), 64'd0);
    chk("midreset_replace_vld", 64'(replace_vld), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd1);
    rstn = 1'b1;
    model_clear();
    wait_sweep("second_reset_sweep_len", SETS);
    op(1'b1, a, 20'h55555, 4'b1000, '0, 1'b0, '0);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tagv_array.md
# tagv_array

Parametrised tag/valid store for the set-associative data cache: WAYS ways × 2^INDEX_W sets of {valid, tag}. It has a registered read port with write-first bypass and one-hot plus encoded hit outputs. It selects a victim tag for writeback and includes a hardware invalidate sweeper that runs after reset and on flush. It sits beside the data banks in the cache pipeline: the tag lookup is issued in the address stage and compared in the following stage.

## Interface
- WAYS, 4, number of ways (power of two, 2..8)
- INDEX_W, 6, set index width; SETS = 2^INDEX_W
- TAG_W, 20, tag width; tag = addr[31:32-TAG_W]
- OFFSET_W, 6, line offset width; index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]; TAG_W+INDEX_W+OFFSET_W = 32
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, asynchronous, active-low
- r_en  in  1  lookup request; samples r_addr
- r_addr  in  32  lookup address
- tag  in  TAG_W  compare tag, presented in the cycle after r_en
- w_addr  in  32  write/invalidate address
- we  in  WAYS  per-way write of {1, w_addr tag}
- inv_set  in  1  clear valid in all ways at w_addr's index
- inv_all  in  1  start full invalidate sweep
- way_sel  in  WAYS  one-hot victim way
- hit  out  WAYS  per-way hit
- cache_hit  out  1  OR of hit
- hit_way  out  log2(WAYS)  encoded index of lowest set hit bit
- multi_hit  out  1  more than one hit bit set (error)
- replace_tag  out  TAG_W  tag of way_sel way at the looked-up set
- replace_vld  out  1  valid of way_sel way at the looked-up set
- busy  out  1  sweep in progress; lookups and writes are refused

## Operation
- Storage: one SETS×(TAG_W+1) array per way. There is one write port at the w_addr index and one read port at the r_addr index.
- Read: on an edge with r_en=1 the array outputs for r_addr's index are captured into rd_q[way]. rd_q holds when r_en=0.
- Bypass: if a write or invalidate hits the same index on the same edge as a read, rd_q captures the post-write value (write-first), per way.
- Compare: hit[i] = rd_q[i].valid && rd_q[i].tag == tag && !busy. It is combinational from rd_q and tag.
- Victim: replace_tag/replace_vld are taken from rd_q[way_sel]. If way_sel is not one-hot, both outputs are 0. During busy, replace_vld is 0.
- FSM states:
  - SWEEP: each cycle writes {0,0} to all ways at index cnt, then increments cnt. Move to READY after cnt=SETS-1 is written.
  - READY: services we and inv_set.
- Entry into SWEEP: leaving reset, or inv_all=1 in READY; cnt is cleared to 0.
- inv_all=1 during SWEEP restarts cnt at 0.
- Priority in READY: inv_set over we. When inv_set=1, we is ignored for that cycle.
- In SWEEP, we and inv_set are ignored. They are dropped, not queued.
- cnt is INDEX_W+1 bits wide; the terminal compare is on SETS-1, with no wrap into index 0.
- rd_q is cleared when the sweep completes so no stale hit survives a flush.

## Timing
- Reset values: busy=1, FSM=SWEEP, cnt=0, rd_q all zero. Outputs are hit=0, cache_hit=0, hit_way=0, multi_hit=0, replace_tag=0, replace_vld=0.
- Sweep length is exactly SETS cycles. busy falls on the edge after index SETS-1 is written.
  - For the defaults: rstn rises before edge 0; indexes 0..63 are written on edges 0..63; busy=0 after edge 63.
- Lookup latency is 1 cycle. r_en at edge N gives hit, hit_way, replace_* valid during cycle N+1, which is combinational from rd_q.
- A write at edge N is visible to a lookup sampled at edge N via the bypass, and to any later lookup.
- rstn low mid-sweep or mid-lookup immediately forces the reset values. Sweep restarts from 0 after release.

## Test plan
- Reset release -> busy=1 for exactly 64 cycles (defaults). Every later lookup then shows hit=0 and replace_vld=0 for all 64 sets.
- Write we=4'b0100 at w_addr=0xABCDE040, then r_en at r_addr=0xABCDE040 with tag=0xABCDE next cycle -> hit=4'b0100, hit_way=2, cache_hit=1, multi_hit=0.
- Same-edge write we=4'b0001 and read, both at index 5 -> next cycle hit[0]=1 (bypass). The same test with inv_set=1 instead of the write -> hit[0]=0.
- Fill way1 with tag 0x12345 at index 9; lookup index 9 with way_sel=4'b0010 -> replace_tag=0x12345, replace_vld=1. With way_sel=4'b0011 -> replace_tag=0, replace_vld=0.
- inv_all in READY, then inv_all again at sweep cycle 30 -> busy stays high 30+64 cycles. A we asserted during busy is not stored.
- Force the same tag into way0 and way3 at one index -> hit=4'b1001, hit_way=0, multi_hit=1. Drop rstn mid-lookup -> all outputs 0 immediately.
